// File: rtl/step_pulse_conditioner_pkg.sv
// Shared types and helpers for the STEP pulse conditioner.
// Optional position counters: STEP_COND_POS_CNT_EN.
package step_pulse_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } st_e;

  // Timer holds max(high, gap) - 1; never narrower than one bit
  function automatic int tmr_w(input int hi, input int gap);
    int m;
    m = (hi > gap) ? hi : gap;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/step_pulse_conditioner_channel.sv
// One STEP axis: sync, edge detect, pending queue, FSM, overflow.
// Position counter present only with STEP_COND_POS_CNT_EN.
module step_axis_channel
  import step_pulse_conditioner_pkg::*;
#(
  parameter int STEP_HIGH_CYC = 50,
  parameter int STEP_GAP_CYC  = 50,
  parameter int PEND_W        = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic pulse_i,
  input  logic clr_ovf_i,
`ifdef STEP_COND_POS_CNT_EN
  input  logic pos_clr_i,
  output logic signed [15:0] pos_o,
`endif
  output logic step_o,
  output logic busy_o,
  output logic ovf_o
);

  localparam int TW = tmr_w(STEP_HIGH_CYC, STEP_GAP_CYC);
  localparam logic [TW-1:0] HI_LD = TW'(STEP_HIGH_CYC - 1);
  localparam logic [TW-1:0] GP_LD = TW'(STEP_GAP_CYC - 1);

  logic s1_q, s2_q, d_q;
  logic edg;
  st_e st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic step_q, step_d;
  logic ovf_q, ovf_d;
  logic take, req, pend_nz, pend_full;
  logic enq, deq, drop;

  // Two-flop synchroniser plus delay flop for edge detect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= pulse_i;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign edg       = s2_q & ~d_q & enable_i;
  assign pend_nz   = |pend_q;
  assign pend_full = &pend_q;
  assign req       = enable_i & (pend_nz | edg);

  // State, timer, output and queue registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= ST_IDLE;
      tmr_q  <= '0;
      step_q <= 1'b0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      step_q <= step_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next state: HIGH and GAP always run their full timer
  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q;
    take  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (req) begin
          st_d  = ST_HIGH;
          tmr_d = HI_LD;
          take  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tmr_q == '0) begin
          st_d  = ST_GAP;
          tmr_d = GP_LD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          if (req) begin
            st_d  = ST_HIGH;
            tmr_d = HI_LD;
            take  = 1'b1;
          end else begin
            st_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Outputs: STEP is registered from the next state
  always_comb begin
    step_d = (st_d == ST_HIGH);
  end

  // Pending queue: a step starts from the queue first, else the edge
  always_comb begin
    deq    = take & pend_nz;
    enq    = edg & ~(take & ~pend_nz);
    drop   = enq & ~deq & pend_full;
    pend_d = pend_q;
    if (!enable_i) begin
      pend_d = '0;
    end else if (enq & ~deq & ~pend_full) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (deq & ~enq) begin
      pend_d = pend_q - PEND_W'(1);
    end
    ovf_d = drop | (ovf_q & ~clr_ovf_i);
  end

  assign step_o = step_q;
  assign busy_o = (st_q != ST_IDLE) | pend_nz;
  assign ovf_o  = ovf_q;

`ifdef STEP_COND_POS_CNT_EN
  logic signed [15:0] pos_q;

  // Count STEP rising edges; clear has priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else if (pos_clr_i) begin
      pos_q <= '0;
    end else if (step_d & ~step_q) begin
      pos_q <= pos_q + 16'sd1;
    end
  end

  assign pos_o = pos_q;
`endif

endmodule

// File: rtl/step_pulse_conditioner.sv
// X/Y STEP conditioner top: two independent axis channels.
// Optional position counters: STEP_COND_POS_CNT_EN.
module step_pulse_conditioner
  import step_pulse_conditioner_pkg::*;
#(
  parameter int STEP_HIGH_CYC = 50,
  parameter int STEP_GAP_CYC  = 50,
  parameter int PEND_W        = 4
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic enable,
  input  logic pulse_x_in,
  input  logic pulse_y_in,
  input  logic clr_ovf,
`ifdef STEP_COND_POS_CNT_EN
  input  logic pos_clr,
`endif
  output logic step_x_out,
  output logic step_y_out,
  output logic busy_x,
  output logic busy_y,
  output logic ovf_x,
  output logic ovf_y
`ifdef STEP_COND_POS_CNT_EN
  ,
  output logic signed [15:0] pos_x,
  output logic signed [15:0] pos_y
`endif
);

  step_axis_channel #(
    .STEP_HIGH_CYC(STEP_HIGH_CYC),
    .STEP_GAP_CYC (STEP_GAP_CYC),
    .PEND_W       (PEND_W)
  ) u_x (
    .clk_i    (sysclk),
    .rst_ni   (rst_n),
    .enable_i (enable),
    .pulse_i  (pulse_x_in),
    .clr_ovf_i(clr_ovf),
`ifdef STEP_COND_POS_CNT_EN
    .pos_clr_i(pos_clr),
    .pos_o    (pos_x),
`endif
    .step_o   (step_x_out),
    .busy_o   (busy_x),
    .ovf_o    (ovf_x)
  );

  step_axis_channel #(
    .STEP_HIGH_CYC(STEP_HIGH_CYC),
    .STEP_GAP_CYC (STEP_GAP_CYC),
    .PEND_W       (PEND_W)
  ) u_y (
    .clk_i    (sysclk),
    .rst_ni   (rst_n),
    .enable_i (enable),
    .pulse_i  (pulse_y_in),
    .clr_ovf_i(clr_ovf),
`ifdef STEP_COND_POS_CNT_EN
    .pos_clr_i(pos_clr),
    .pos_o    (pos_y),
`endif
    .step_o   (step_y_out),
    .busy_o   (busy_y),
    .ovf_o    (ovf_y)
  );

endmodule
